// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit paths: frame states,
// the default word width and the parity-type encoding.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing front end of the UART receiver: line synchronizer, per-bit edge counter
// and the bit decision. Define UART_RX_MAJORITY_EN for a 2-of-3 vote around mid-bit.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic rx_in,
  input  logic run,
  output logic rx_s,
  output logic sample_stb,
  output logic bit_val,
  output logic bit_end
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] MID_PT  = CNT_W'(PRESCALE / 2);
  localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(PRESCALE - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic [CNT_W-1:0] edge_cnt_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      edge_cnt_reg <= '0;
    end else begin
      sync1_reg    <= rx_in;
      sync2_reg    <= sync1_reg;
      edge_cnt_reg <= edge_cnt_next;
    end
  end

  // Held at zero while idle so the first frame cycle starts the bit at count 0.
  always_comb begin
    edge_cnt_next = '0;
    if (run && (edge_cnt_reg != LAST_PT)) begin
      edge_cnt_next = edge_cnt_reg + CNT_W'(1);
    end
  end

  assign rx_s    = sync2_reg;
  assign bit_end = run && (edge_cnt_reg == LAST_PT);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] EARLY_PT = CNT_W'(PRESCALE / 2 - 1);
  localparam logic [CNT_W-1:0] LATE_PT  = CNT_W'(PRESCALE / 2 + 1);

  logic early_reg;
  logic mid_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      early_reg <= 1'b1;
      mid_reg   <= 1'b1;
    end else begin
      if (edge_cnt_reg == EARLY_PT) early_reg <= sync2_reg;
      if (edge_cnt_reg == MID_PT)   mid_reg   <= sync2_reg;
    end
  end

  assign sample_stb = run && (edge_cnt_reg == LATE_PT);
  assign bit_val    = (early_reg & mid_reg) | (early_reg & sync2_reg) | (mid_reg & sync2_reg);
`else
  assign sample_stb = run && (edge_cnt_reg == MID_PT);
  assign bit_val    = sync2_reg;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first shift register, parity/stop checking and
// registered result strobes. UART_RX_MAJORITY_EN selects majority bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  busy
);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);

  uart_state_e           state_reg, state_next;
  logic [BC_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  par_fail_reg, par_fail_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  par_err_reg, par_err_next;
  logic                  stp_err_reg, stp_err_next;

  logic rx_s;
  logic sample_stb;
  logic bit_val;
  logic bit_end;
  logic exp_par;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk       (CLK),
    .srst      (RST),
    .rx_in     (RX_IN),
    .run       (state_reg != IDLE),
    .rx_s      (rx_s),
    .sample_stb(sample_stb),
    .bit_val   (bit_val),
    .bit_end   (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      p_data_reg     <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= PAR_EVEN;
      par_fail_reg   <= 1'b0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      p_data_reg     <= p_data_next;
      par_en_reg     <= par_en_next;
      par_typ_reg    <= par_typ_next;
      par_fail_reg   <= par_fail_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;
    end
  end

  assign exp_par = (^shift_reg) ^ (par_typ_reg == PAR_ODD);

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    p_data_next     = p_data_reg;
    par_en_next     = par_en_reg;
    par_typ_next    = par_typ_reg;
    par_fail_next   = par_fail_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next    = START;
          bit_cnt_next  = '0;
          par_fail_next = 1'b0;
          par_en_next   = PAR_EN;
          par_typ_next  = PAR_TYP;
        end
      end
      START: begin
        if (sample_stb && bit_val) begin
          state_next = IDLE;
        end else if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (sample_stb) begin
          shift_next   = {bit_val, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
        end
        if (bit_end && (bit_cnt_reg == BC_W'(DATA_WIDTH))) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_stb && (bit_val != exp_par)) begin
          par_fail_next = 1'b1;
        end
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        // Leave at the stop sample point so a new start bit half a bit later is caught.
        if (sample_stb) begin
          state_next = IDLE;
          if (!bit_val) begin
            stp_err_next = 1'b1;
          end else if (par_fail_reg) begin
            par_err_next = 1'b1;
          end else begin
            p_data_next     = shift_reg;
            data_valid_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign P_DATA     = p_data_reg;
  assign Data_Valid = data_valid_reg;
  assign Par_Err    = par_err_reg;
  assign Stp_Err    = stp_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE = 8: good frames, parity/stop errors,
// false start, majority glitch rejection (UART_RX_MAJORITY_EN) and mid-frame reset.
module tb_uart_rx;

  localparam int P = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int K_NOPAR = 77 + MAJ;
  localparam int K_PAR   = 85 + MAJ;
  // RX_IN driven low in loop step 0 reaches rx_s at step 2; START is entered at step 3.
  localparam int DET = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int   busy_rise, strobe_t, strobe_kind, n_strobe, n_overlap;
  logic pre_busy, strobe_busy;

  uart_rx #(
    .PRESCALE  (P),
    .DATA_WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .Par_Err   (Par_Err),
    .Stp_Err   (Stp_Err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
  endtask

  // Drives one frame bit-by-bit and records busy/strobe observations per cycle.
  task automatic run_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                           input logic pbit, input logic sbit, input int glitch_t, input int chg_t);
    logic [11:0] bits;
    int          nb;
    logic        rx;
    logic        prev_busy;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (pen) begin
      bits[9] = pbit; bits[10] = sbit; nb = 11;
    end else begin
      bits[9] = sbit; nb = 10;
    end
    PAR_EN = pen;
    PAR_TYP = ptyp;
    busy_rise = -1; strobe_t = -1; strobe_kind = 0; n_strobe = 0; n_overlap = 0;
    pre_busy = 1'b0; strobe_busy = 1'b1; prev_busy = 1'b0;
    for (int t = 0; t < nb * P + 12; t++) begin
      @(posedge CLK); #1;
      if (busy === 1'b1 && busy_rise < 0) busy_rise = t;
      if (Data_Valid === 1'b1 || Par_Err === 1'b1 || Stp_Err === 1'b1) begin
        n_strobe++;
        if ((int'(Data_Valid) + int'(Par_Err) + int'(Stp_Err)) > 1) n_overlap++;
        if (strobe_t < 0) begin
          strobe_t = t;
          strobe_kind = Data_Valid ? 1 : (Par_Err ? 2 : 3);
          pre_busy = prev_busy;
          strobe_busy = busy;
        end
      end
      prev_busy = busy;
      rx = (t < nb * P) ? bits[t / P] : 1'b1;
      if (t == glitch_t) rx = ~rx;
      if (t == chg_t) PAR_EN = ~pen;
      RX_IN = rx;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (P_DATA !== 8'h00) begin
      $display("FAIL reset_pdata: got %h want 00", P_DATA); miscompares++;
    end
    vectors++;
    if ({Data_Valid, Par_Err, Stp_Err, busy} !== 4'b0000) begin
      $display("FAIL reset_flags: got dv/pe/se/busy=%b want 0000", {Data_Valid, Par_Err, Stp_Err, busy});
      miscompares++;
    end
    $display("reset: P_DATA=%h flags=%b", P_DATA, {Data_Valid, Par_Err, Stp_Err, busy});
  endtask

  task automatic test_good_no_parity;
    idle(4);
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    vectors++;
    if (busy_rise !== DET) begin
      $display("FAIL nopar_detect: busy rose at %0d want %0d", busy_rise, DET); miscompares++;
    end
    vectors++;
    if (strobe_kind !== 1 || strobe_t - busy_rise !== K_NOPAR) begin
      $display("FAIL nopar_strobe: kind %0d at k=%0d want kind 1 at k=%0d", strobe_kind, strobe_t - busy_rise, K_NOPAR);
      miscompares++;
    end
    vectors++;
    if (n_strobe !== 1 || n_overlap !== 0) begin
      $display("FAIL nopar_width: strobe cycles %0d overlap %0d want 1 and 0", n_strobe, n_overlap); miscompares++;
    end
    vectors++;
    if ({pre_busy, strobe_busy} !== 2'b10) begin
      $display("FAIL nopar_busy: busy before/at strobe %b want 10", {pre_busy, strobe_busy}); miscompares++;
    end
    vectors++;
    if (P_DATA !== 8'hA5) begin
      $display("FAIL nopar_data: got %h want a5", P_DATA); miscompares++;
    end
    $display("frame a5 nopar: kind=%0d k=%0d P_DATA=%h", strobe_kind, strobe_t - busy_rise, P_DATA);
  endtask

  task automatic test_odd_parity;
    idle(4);
    // 0x3C has four ones, so odd parity bit is 1; PAR_EN flips mid-frame and must be ignored.
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 20);
    PAR_EN = 1'b1;
    vectors++;
    if (strobe_kind !== 1 || strobe_t - busy_rise !== K_PAR) begin
      $display("FAIL oddpar_strobe: kind %0d at k=%0d want kind 1 at k=%0d", strobe_kind, strobe_t - busy_rise, K_PAR);
      miscompares++;
    end
    vectors++;
    if (n_strobe !== 1) begin
      $display("FAIL oddpar_width: strobe cycles %0d want 1", n_strobe); miscompares++;
    end
    vectors++;
    if (P_DATA !== 8'h3C) begin
      $display("FAIL oddpar_data: got %h want 3c", P_DATA); miscompares++;
    end
    $display("frame 3c oddpar: kind=%0d k=%0d P_DATA=%h", strobe_kind, strobe_t - busy_rise, P_DATA);
  endtask

  task automatic test_parity_error;
    idle(4);
    run_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    vectors++;
    if (strobe_kind !== 2 || strobe_t - busy_rise !== K_PAR) begin
      $display("FAIL parerr_strobe: kind %0d at k=%0d want kind 2 at k=%0d", strobe_kind, strobe_t - busy_rise, K_PAR);
      miscompares++;
    end
    vectors++;
    if (n_strobe !== 1) begin
      $display("FAIL parerr_width: strobe cycles %0d want 1", n_strobe); miscompares++;
    end
    vectors++;
    if (P_DATA !== 8'h3C) begin
      $display("FAIL parerr_hold: got %h want 3c", P_DATA); miscompares++;
    end
    $display("frame 01 evenpar bad: kind=%0d k=%0d P_DATA=%h", strobe_kind, strobe_t - busy_rise, P_DATA);
  endtask

  task automatic test_stop_error;
    idle(4);
    run_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    vectors++;
    if (strobe_kind !== 3 || strobe_t - busy_rise !== K_NOPAR) begin
      $display("FAIL stperr_strobe: kind %0d at k=%0d want kind 3 at k=%0d", strobe_kind, strobe_t - busy_rise, K_NOPAR);
      miscompares++;
    end
    vectors++;
    if (n_strobe !== 1 || P_DATA !== 8'h3C) begin
      $display("FAIL stperr_hold: strobe cycles %0d P_DATA %h want 1 and 3c", n_strobe, P_DATA); miscompares++;
    end
    $display("frame 12 stop=0: kind=%0d k=%0d P_DATA=%h", strobe_kind, strobe_t - busy_rise, P_DATA);
    idle(20);
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    vectors++;
    if (busy_rise !== DET || strobe_kind !== 1 || strobe_t - busy_rise !== K_NOPAR) begin
      $display("FAIL after_stperr: rise %0d kind %0d k=%0d want %0d 1 %0d", busy_rise, strobe_kind, strobe_t - busy_rise, DET, K_NOPAR);
      miscompares++;
    end
    vectors++;
    if (P_DATA !== 8'h55) begin
      $display("FAIL after_stperr_data: got %h want 55", P_DATA); miscompares++;
    end
    $display("frame 55 nopar: kind=%0d k=%0d P_DATA=%h", strobe_kind, strobe_t - busy_rise, P_DATA);
  endtask

  task automatic test_false_start;
    int seen_busy;
    int strobes;
    idle(4);
    seen_busy = 0;
    strobes = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge CLK); #1;
      if (busy === 1'b1) seen_busy++;
      if (Data_Valid || Par_Err || Stp_Err) strobes++;
      RX_IN = (t < 2) ? 1'b0 : 1'b1;
    end
    vectors++;
    if (seen_busy == 0 || busy !== 1'b0) begin
      $display("FAIL false_start_busy: busy cycles %0d final busy %b want >0 and 0", seen_busy, busy); miscompares++;
    end
    vectors++;
    if (strobes !== 0 || P_DATA !== 8'h55) begin
      $display("FAIL false_start_quiet: strobes %0d P_DATA %h want 0 and 55", strobes, P_DATA); miscompares++;
    end
    $display("false start: busy cycles=%0d strobes=%0d P_DATA=%h", seen_busy, strobes, P_DATA);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_glitch;
    idle(4);
    // One-cycle dip centred on the bit-0 sample window of a 1 data bit.
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 13, -1);
    vectors++;
    if (strobe_kind !== 1 || P_DATA !== 8'hA5) begin
      $display("FAIL glitch_reject: kind %0d P_DATA %h want 1 and a5", strobe_kind, P_DATA); miscompares++;
    end
    $display("frame a5 glitch: kind=%0d P_DATA=%h", strobe_kind, P_DATA);
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [9:0] bits;
    idle(4);
    PAR_EN = 1'b0;
    bits = {1'b1, 8'h3C, 1'b0};
    for (int t = 0; t < 40; t++) begin
      @(posedge CLK); #1;
      if (t == 30) begin
        vectors++;
        if (busy !== 1'b1) begin
          $display("FAIL midrst_pre: busy %b want 1", busy); miscompares++;
        end
      end
      if (t == 31) begin
        vectors++;
        if (P_DATA !== 8'h00) begin
          $display("FAIL midrst_pdata: got %h want 00", P_DATA); miscompares++;
        end
        vectors++;
        if ({Data_Valid, Par_Err, Stp_Err, busy} !== 4'b0000) begin
          $display("FAIL midrst_flags: got %b want 0000", {Data_Valid, Par_Err, Stp_Err, busy}); miscompares++;
        end
        $display("mid-frame reset: P_DATA=%h flags=%b", P_DATA, {Data_Valid, Par_Err, Stp_Err, busy});
      end
      RST = (t == 30);
      RX_IN = (t >= 30) ? 1'b1 : bits[t / P];
    end
    RST = 1'b0;
    idle(6);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    vectors++;
    if (busy_rise !== DET || strobe_kind !== 1 || strobe_t - busy_rise !== K_NOPAR || P_DATA !== 8'hFF) begin
      $display("FAIL after_midrst: rise %0d kind %0d k=%0d data %h want %0d 1 %0d ff",
               busy_rise, strobe_kind, strobe_t - busy_rise, P_DATA, DET, K_NOPAR);
      miscompares++;
    end
    $display("frame ff after reset: kind=%0d k=%0d P_DATA=%h", strobe_kind, strobe_t - busy_rise, P_DATA);
  endtask

  initial begin
    test_reset();
    test_good_no_parity();
    test_odd_parity();
    test_parity_error();
    test_stop_error();
    test_false_start();
`ifdef UART_RX_MAJORITY_EN
    test_glitch();
`endif
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link, the receiving end of the 8-bit, LSB-first, optional-parity frame produced by the transmit path. Oversamples `RX_IN` at `PRESCALE` clocks per bit and detects the start bit. Deserializes the data bits, then checks the parity and stop bits. Presents `P_DATA` with a one-cycle `Data_Valid` strobe, or a one-cycle error strobe, to the host-side logic.

## Interface
- `PRESCALE`, default 8: `CLK` cycles per bit. Even, ≥ 4.
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `RX_IN` input 1: serial line, asynchronous, idle high.
- `PAR_EN` input 1: 1 means a parity bit follows the data.
- `PAR_TYP` input 1: 0 is even parity, 1 is odd parity.
- `P_DATA` output `DATA_WIDTH`: received word.
- `Data_Valid` output 1: one-cycle strobe when a frame is accepted.
- `Par_Err` output 1: one-cycle strobe when the parity bit mismatches.
- `Stp_Err` output 1: one-cycle strobe when the stop bit is sampled 0.
- `busy` output 1: high from leaving IDLE until returning to IDLE.

## Operation
- **Synchronizer:** `RX_IN` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE → START:** when `rx_s` = 0. Clear `edge_cnt` and `bit_cnt`. Latch `PAR_EN` and `PAR_TYP`; mid-frame changes to these inputs are ignored.
- **Bit timing:** `edge_cnt` counts 0..`PRESCALE`-1 per bit and wraps. Each bit is sampled at `edge_cnt` = `PRESCALE`/2. Bit i is sampled at cycle k = i·`PRESCALE` + `PRESCALE`/2, where k = 0 is the IDLE→START cycle.
- **START:**
  - Sample = 1: glitch. Return to IDLE; no strobe.
  - Sample = 0: at wrap, go to DATA.
- **DATA:** shift the sample into the shift register LSB-first. After `DATA_WIDTH` samples, at wrap go to PARITY if latched `PAR_EN`, else to STOP.
- **PARITY:** expected bit = (^data) XOR latched `PAR_TYP`. A mismatch sets the internal parity-fail flag. At wrap go to STOP.
- **STOP, at the sample point:**
  - If the sample is 0: `Stp_Err` = 1.
  - Else if parity failed: `Par_Err` = 1.
  - Else: `P_DATA` ← shift register and `Data_Valid` = 1.
  - In all cases go to IDLE at once, without waiting for the stop wrap. This allows back-to-back frames with a half-bit margin.
- **Strobe exclusivity:** at most one of `Data_Valid`, `Par_Err`, `Stp_Err` is high in any cycle.
- **Data hold:** `P_DATA` holds its value until the next accepted frame. Errored frames do not update it.
- **Mid-frame reset:** `RST` aborts any frame, returns to IDLE and clears all state.

## Timing
- **Reset values:** `P_DATA` = 0, `Data_Valid` = 0, `Par_Err` = 0, `Stp_Err` = 0, `busy` = 0. State IDLE, all counters 0, synchronizer flops = 1.
- **Detection latency:** the falling edge of `RX_IN` reaches `rx_s` 2 cycles later.
- **Strobe timing:** strobes are registered and go high at k = s·`PRESCALE` + `PRESCALE`/2 + 1, where s = 1 + `DATA_WIDTH` (+1 if parity).
  - `PRESCALE` = 8, no parity: k = 77.
  - `PRESCALE` = 8, with parity: k = 85.
- **Strobe width:** exactly 1 cycle. There is no backpressure; the host must take the data on the strobe.
- **`busy`:** high from cycle k = 0 through the cycle before the strobe.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:**
  - Each bit decision is the 2-of-3 majority of samples at `edge_cnt` = `PRESCALE`/2 − 1, `PRESCALE`/2 and `PRESCALE`/2 + 1.
  - The decision is taken at `PRESCALE`/2 + 1, so all sample points and strobes move 1 cycle later (77 → 78, 85 → 86).
  - A single-cycle glitch on the line is rejected.
- **Undefined:** single sample at `PRESCALE`/2, with the timing given above.

## Structure
- **Shared package `uart_pkg`:**
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - `DATA_WIDTH` default.
  - Parity-type constants `PAR_EVEN` = 0 and `PAR_ODD` = 1, shared with the transmit path.
- **Sub-module `uart_rx_sampler`:** contains the synchronizer, `edge_cnt` and the sample/majority logic. It outputs `sample_stb`, `bit_val` and `bit_end`.
- **Top level:** the FSM, the shift register, the parity check and the output registers.

## Test plan
- **Good frame, no parity:** `PRESCALE` = 8, `PAR_EN` = 0, send 0xA5 → `P_DATA` = 0xA5, `Data_Valid` high 1 cycle at k = 77, no error strobes.
- **Good frame, odd parity:** `PAR_EN` = 1, `PAR_TYP` = 1, send 0x3C with parity bit 1 → `Data_Valid` at k = 85, `P_DATA` = 0x3C.
- **Parity error:** even parity, send 0x01 with parity bit 0 → `Par_Err` pulses 1 cycle, `Data_Valid` stays 0, `P_DATA` keeps its previous value.
- **Stop error:** stop bit driven 0 → `Stp_Err` pulses 1 cycle, then the FSM is in IDLE and the next frame 0x55 is received correctly.
- **False start:** `RX_IN` low for 2 cycles, then high → return to IDLE, `busy` drops, no strobe. With `UART_RX_MAJORITY_EN`, a 1-cycle glitch inside a data bit does not change `P_DATA`.
- **Reset mid-frame:** assert `RST` during DATA → next cycle all outputs are 0 and the state is IDLE. A following frame 0xFF is received correctly.
